// File: rtl/cpu_host_loader_pkg.sv
// Shared opcodes, FSM states and limits for the host-side loader of the CPU's
// external instruction/data memory ports.
package cpu_host_loader_pkg;

   typedef enum logic [2:0] {
      OP_NOP       = 3'd0,
      OP_IMEM_WR   = 3'd1,
      OP_DMEM_WR   = 3'd2,
      OP_IMEM_RD   = 3'd3,
      OP_DMEM_RD   = 3'd4,
      OP_RUN       = 3'd5,
      OP_HALT      = 3'd6,
      OP_RD_CYCLES = 3'd7
   } opcode_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_WAIT,
      S_RESP
   } state_e;

   typedef enum logic [1:0] {
      SRC_IMEM,
      SRC_DMEM,
      SRC_CNT
   } rsp_src_e;

   localparam int RD_LAT_MAX = 4;

   // Memory commands are the ones that must stall while the core owns the SRAMs.
   function automatic logic is_mem_op(input opcode_e op);
      return op inside {OP_IMEM_WR, OP_DMEM_WR, OP_IMEM_RD, OP_DMEM_RD};
   endfunction

endpackage

// File: rtl/cpu_host_loader.sv
// Host command initiator for the CPU ext memory ports and enable line.
// Optional run-cycle counter (RD_CYCLES) enabled by defining HOST_RUN_CYCLE_CNT_EN.
module cpu_host_loader
   import cpu_host_loader_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [63:0]       cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [63:0]       rsp_data,
   output logic              cpu_enable,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_wen,
   output logic              imem_ren,
   output logic [31:0]       imem_wdata,
   input  logic [31:0]       imem_rdata,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic              dmem_wen,
   output logic              dmem_ren,
   output logic [63:0]       dmem_wdata,
   input  logic [63:0]       dmem_rdata
);

   localparam int WAIT_W = $clog2(RD_LAT_MAX);
   localparam logic [WAIT_W-1:0] WAIT_INIT = (RD_LAT > 1) ? WAIT_W'(RD_LAT - 2) : '0;

   state_e              state_q, state_d;
   rsp_src_e            src_q, src_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                cpu_enable_q, cpu_enable_d;
   logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
   logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
   logic [31:0]         imem_wdata_q, imem_wdata_d;
   logic [63:0]         dmem_wdata_q, dmem_wdata_d;
   logic                imem_wen_q, imem_wen_d;
   logic                imem_ren_q, imem_ren_d;
   logic                dmem_wen_q, dmem_wen_d;
   logic                dmem_ren_q, dmem_ren_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [63:0]         rsp_data_q, rsp_data_d;
   logic [63:0]         cnt_value;

   opcode_e op;
   logic    accept;

   assign op        = opcode_e'(cmd_op);
   // Memory ops are refused while the core runs; HALT is always accepted so the stall resolves.
   assign cmd_ready = ~arst & (state_q == S_IDLE) & (~cpu_enable_q | ~is_mem_op(op));
   assign accept    = cmd_valid & cmd_ready;

`ifdef HOST_RUN_CYCLE_CNT_EN
   logic [63:0] cycles_q, cycles_d;

   always_comb begin
      cycles_d = cycles_q;
      if (accept && (op == OP_RUN) && !cpu_enable_q) begin
         cycles_d = '0;
      end else if (cpu_enable_q) begin
         cycles_d = cycles_q + 64'd1;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         cycles_q <= '0;
      end else begin
         cycles_q <= cycles_d;
      end
   end

   assign cnt_value = cycles_q;
`else
   assign cnt_value = '0;
`endif

   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      wait_d       = wait_q;
      cpu_enable_d = cpu_enable_q;
      imem_addr_d  = imem_addr_q;
      dmem_addr_d  = dmem_addr_q;
      imem_wdata_d = imem_wdata_q;
      dmem_wdata_d = dmem_wdata_q;
      imem_wen_d   = 1'b0;
      imem_ren_d   = 1'b0;
      dmem_wen_d   = 1'b0;
      dmem_ren_d   = 1'b0;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (op)
                  OP_IMEM_WR: begin
                     imem_addr_d  = cmd_addr;
                     imem_wdata_d = cmd_data[31:0];
                     imem_wen_d   = 1'b1;
                     state_d      = S_WRITE;
                  end
                  OP_DMEM_WR: begin
                     dmem_addr_d  = cmd_addr;
                     dmem_wdata_d = cmd_data;
                     dmem_wen_d   = 1'b1;
                     state_d      = S_WRITE;
                  end
                  OP_IMEM_RD: begin
                     imem_addr_d = cmd_addr;
                     imem_ren_d  = 1'b1;
                     src_d       = SRC_IMEM;
                     state_d     = S_READ;
                  end
                  OP_DMEM_RD: begin
                     dmem_addr_d = cmd_addr;
                     dmem_ren_d  = 1'b1;
                     src_d       = SRC_DMEM;
                     state_d     = S_READ;
                  end
                  OP_RUN:  cpu_enable_d = 1'b1;
                  OP_HALT: cpu_enable_d = 1'b0;
`ifdef HOST_RUN_CYCLE_CNT_EN
                  OP_RD_CYCLES: begin
                     src_d   = SRC_CNT;
                     state_d = S_RESP;
                  end
`endif
                  default: ;
               endcase
            end
         end
         S_WRITE: state_d = S_IDLE;
         S_READ: begin
            if (RD_LAT > 1) begin
               wait_d  = WAIT_INIT;
               state_d = S_WAIT;
            end else begin
               state_d = S_RESP;
            end
         end
         S_WAIT: begin
            if (wait_q == '0) begin
               state_d = S_RESP;
            end else begin
               wait_d = wait_q - WAIT_W'(1);
            end
         end
         // First S_RESP cycle is the one where read data is valid; capture it, then hold.
         S_RESP: begin
            if (!rsp_valid_q) begin
               rsp_valid_d = 1'b1;
               case (src_q)
                  SRC_IMEM: rsp_data_d = {32'd0, imem_rdata};
                  SRC_DMEM: rsp_data_d = dmem_rdata;
                  default:  rsp_data_d = cnt_value;
               endcase
            end else if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q      <= S_IDLE;
         src_q        <= SRC_IMEM;
         wait_q       <= '0;
         cpu_enable_q <= 1'b0;
         imem_addr_q  <= '0;
         dmem_addr_q  <= '0;
         imem_wdata_q <= '0;
         dmem_wdata_q <= '0;
         imem_wen_q   <= 1'b0;
         imem_ren_q   <= 1'b0;
         dmem_wen_q   <= 1'b0;
         dmem_ren_q   <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         wait_q       <= wait_d;
         cpu_enable_q <= cpu_enable_d;
         imem_addr_q  <= imem_addr_d;
         dmem_addr_q  <= dmem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         dmem_wdata_q <= dmem_wdata_d;
         imem_wen_q   <= imem_wen_d;
         imem_ren_q   <= imem_ren_d;
         dmem_wen_q   <= dmem_wen_d;
         dmem_ren_q   <= dmem_ren_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
      end
   end

   assign cpu_enable = cpu_enable_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wen   = imem_wen_q;
   assign imem_ren   = imem_ren_q;
   assign imem_wdata = imem_wdata_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wen   = dmem_wen_q;
   assign dmem_ren   = dmem_ren_q;
   assign dmem_wdata = dmem_wdata_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_cpu_host_loader.sv
// Bench for cpu_host_loader: lane 0 uses RD_LAT=1, lane 1 uses RD_LAT=3, each with a
// synchronous SRAM model; HOST_RUN_CYCLE_CNT_EN selects the expected RD_CYCLES behaviour.
module tb_cpu_host_loader;
   import cpu_host_loader_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        arst [2];
   logic        cmdValid;
   logic [2:0]  cmdOp;
   logic [63:0] cmdAddr, cmdData;
   logic        rspReady;
   logic        selB;

   logic        cmdValidV [2], cmdReady [2], rspValid [2], cpuEn [2];
   logic        imemWen [2], imemRen [2], dmemWen [2], dmemRen [2];
   logic [63:0] rspData [2], imemAddr [2], dmemAddr [2], dmemWdata [2], dmemRdata [2];
   logic [31:0] imemWdata [2], imemRdata [2];

   int vectors = 0, miscompares = 0, cycle = 0, acceptCycle = 0;
   int imemWenCnt = 0, dmemStrobeCnt = 0, strobeClash = 0;
   logic [63:0] lastIAddr = '0;
   logic [31:0] lastIWdata = '0;
   logic [31:0] expImem [2][256];
   logic [63:0] expDmem [2][256];

   logic        curReady, curRspValid;
   logic [63:0] curRspData;
   assign curReady    = cmdReady[selB];
   assign curRspValid = rspValid[selB];
   assign curRspData  = rspData[selB];

   // Two DUT lanes, each with its own SRAMs whose read data is valid only LAT cycles after ren
   generate
      for (genvar g = 0; g < 2; g++) begin : lane
         localparam int LAT = (g == 0) ? 1 : 3;
         logic [31:0] imemArr [256];
         logic [63:0] dmemArr [256];
         logic [7:0]  iIdx [LAT];
         logic [7:0]  dIdx [LAT];
         logic        iVld [LAT];
         logic        dVld [LAT];

         assign cmdValidV[g] = cmdValid && (selB == 1'(g));

         cpu_host_loader #(.ADDR_W(64), .RD_LAT(LAT)) dut (
            .clk        (clk),
            .arst       (arst[g]),
            .cmd_valid  (cmdValidV[g]),
            .cmd_ready  (cmdReady[g]),
            .cmd_op     (cmdOp),
            .cmd_addr   (cmdAddr),
            .cmd_data   (cmdData),
            .rsp_valid  (rspValid[g]),
            .rsp_ready  (rspReady),
            .rsp_data   (rspData[g]),
            .cpu_enable (cpuEn[g]),
            .imem_addr  (imemAddr[g]),
            .imem_wen   (imemWen[g]),
            .imem_ren   (imemRen[g]),
            .imem_wdata (imemWdata[g]),
            .imem_rdata (imemRdata[g]),
            .dmem_addr  (dmemAddr[g]),
            .dmem_wen   (dmemWen[g]),
            .dmem_ren   (dmemRen[g]),
            .dmem_wdata (dmemWdata[g]),
            .dmem_rdata (dmemRdata[g])
         );

         initial begin
            for (int i = 0; i < 256; i++) begin
               imemArr[i] = '0;
               dmemArr[i] = '0;
            end
            for (int i = 0; i < LAT; i++) begin
               iIdx[i] = '0; dIdx[i] = '0; iVld[i] = 1'b0; dVld[i] = 1'b0;
            end
         end

         always @(posedge clk) begin
            if (imemWen[g]) imemArr[imemAddr[g][9:2]] <= imemWdata[g];
            if (dmemWen[g]) dmemArr[dmemAddr[g][10:3]] <= dmemWdata[g];
            iVld[0] <= imemRen[g];
            iIdx[0] <= imemAddr[g][9:2];
            dVld[0] <= dmemRen[g];
            dIdx[0] <= dmemAddr[g][10:3];
            for (int i = 1; i < LAT; i++) begin
               iVld[i] <= iVld[i-1]; iIdx[i] <= iIdx[i-1];
               dVld[i] <= dVld[i-1]; dIdx[i] <= dIdx[i-1];
            end
         end

         assign imemRdata[g] = iVld[LAT-1] ? imemArr[iIdx[LAT-1]] : 32'hDEAD_0BAD;
         assign dmemRdata[g] = dVld[LAT-1] ? dmemArr[dIdx[LAT-1]] : 64'hBAD0_BAD0_BAD0_BAD0;
      end
   endgenerate

   // Strobe monitor: pulse counts on lane 0 and simultaneous-strobe detection on both lanes
   always @(negedge clk) begin
      cycle++;
      if (imemWen[0]) begin
         imemWenCnt++;
         lastIAddr  = imemAddr[0];
         lastIWdata = imemWdata[0];
      end
      if (dmemWen[0] || dmemRen[0]) dmemStrobeCnt++;
      for (int l = 0; l < 2; l++) begin
         if (int'(imemWen[l]) + int'(imemRen[l]) + int'(dmemWen[l]) + int'(dmemRen[l]) > 1)
            strobeClash++;
      end
   end

   task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkIdle(input int l, input string tag);
      checkValue({tag, "_cpuEn"}, 64'(cpuEn[l]), 64'd0);
      checkValue({tag, "_rspValid"}, 64'(rspValid[l]), 64'd0);
      checkValue({tag, "_rspData"}, rspData[l], 64'd0);
      checkValue({tag, "_addr"}, imemAddr[l] | dmemAddr[l], 64'd0);
      checkValue({tag, "_wdata"}, dmemWdata[l] | 64'(imemWdata[l]), 64'd0);
      checkValue({tag, "_strobes"}, 64'({imemWen[l], imemRen[l], dmemWen[l], dmemRen[l]}), 64'd0);
   endtask

   // Present one command on the selected lane and hold it until accepted (bounded)
   task automatic applyStimulus(input opcode_e op, input logic [63:0] addr, input logic [63:0] data);
      int waited = 0;
      @(negedge clk);
      cmdValid = 1'b1; cmdOp = op; cmdAddr = addr; cmdData = data;
      #1;
      while (!curReady && waited < 50) begin
         @(negedge clk);
         #1;
         waited++;
      end
      checkValue({"accept_", op.name()}, 64'(curReady), 64'd1);
      @(posedge clk);
      acceptCycle = cycle;
      #1;
      cmdValid = 1'b0;
      cmdOp    = OP_NOP;
      if (op == OP_IMEM_WR) expImem[selB][addr[9:2]] = data[31:0];
      if (op == OP_DMEM_WR) expDmem[selB][addr[10:3]] = data;
   endtask

   // Wait for a response, hold rsp_ready low for 'hold' cycles, then consume it
   task automatic checkOutput(input string tag, input logic [63:0] expected, input int hold);
      int waited = 0;
      @(negedge clk);
      while (!curRspValid && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkValue({tag, "_valid"}, 64'(curRspValid), 64'd1);
      checkValue({tag, "_data"}, curRspData, expected);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkValue({tag, "_heldValid"}, 64'(curRspValid), 64'd1);
         checkValue({tag, "_heldData"}, curRspData, expected);
      end
      rspReady = 1'b1;
      @(posedge clk);
      #1 rspReady = 1'b0;
      @(negedge clk);
      checkValue({tag, "_drop"}, 64'(curRspValid), 64'd0);
      checkValue({tag, "_cmdReady"}, 64'(curReady), 64'd1);
   endtask

   // The counter should equal the number of cycles between RUN and HALT acceptance
   task automatic checkCycles(input string tag, input int expected);
      int seen = 0;
      applyStimulus(OP_RD_CYCLES, 64'd0, 64'd0);
`ifdef HOST_RUN_CYCLE_CNT_EN
      checkOutput(tag, 64'(expected), 2);
      seen = 0;
`else
      repeat (10) begin
         @(negedge clk);
         if (curRspValid) seen++;
      end
      checkValue({tag, "_noRsp"}, 64'(seen), 64'd0);
      checkValue({tag, "_ready"}, 64'(curReady), 64'd1);
      seen = expected;
`endif
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=still running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int runAt, haltAt, idx, kind, seen;
      logic [63:0] rdata;

      cmdValid = 1'b0; cmdOp = OP_NOP; cmdAddr = '0; cmdData = '0;
      rspReady = 1'b0; selB = 1'b0;
      arst[0] = 1'b1; arst[1] = 1'b1;
      for (int l = 0; l < 2; l++) begin
         for (int i = 0; i < 256; i++) begin
            expImem[l][i] = '0;
            expDmem[l][i] = '0;
         end
      end

      repeat (3) @(negedge clk);
      checkValue("readyInReset", 64'(cmdReady[0]), 64'd0);
      checkIdle(0, "inReset");
      arst[0] = 1'b0; arst[1] = 1'b0;
      @(negedge clk);
      checkIdle(0, "afterReset");
      checkValue("readyAfterReset", 64'(cmdReady[0]), 64'd1);

      applyStimulus(OP_IMEM_WR, 64'h8, 64'h0050_0093);
      repeat (4) @(posedge clk);
      #1;
      checkValue("imemWenPulses", 64'(imemWenCnt), 64'd1);
      checkValue("imemWenAddr", lastIAddr, 64'h8);
      checkValue("imemWenData", 64'(lastIWdata), 64'h0050_0093);
      checkValue("dmemQuiet", 64'(dmemStrobeCnt), 64'd0);
      checkValue("imemAddrHeld", imemAddr[0], 64'h8);

      applyStimulus(OP_DMEM_WR, 64'h10, 64'hDEAD_BEEF_CAFE_F00D);
      applyStimulus(OP_DMEM_RD, 64'h10, 64'd0);
      checkOutput("dmemRdHold", 64'hDEAD_BEEF_CAFE_F00D, 5);

      applyStimulus(OP_IMEM_WR, 64'h20, 64'h00A0_0113);
      applyStimulus(OP_IMEM_RD, 64'h20, 64'd0);
      checkOutput("imemRdZext", 64'h0000_0000_00A0_0113, 0);

      for (int n = 0; n < 24; n++) begin
         idx   = int'($urandom_range(0, 255));
         kind  = int'($urandom_range(0, 3));
         rdata = {$urandom, $urandom};
         case (kind)
            0: applyStimulus(OP_IMEM_WR, 64'(idx) << 2, rdata);
            1: applyStimulus(OP_DMEM_WR, 64'(idx) << 3, rdata);
            2: begin
               applyStimulus(OP_IMEM_RD, 64'(idx) << 2, 64'd0);
               checkOutput("randImemRd", {32'd0, expImem[0][idx]}, int'($urandom_range(0, 3)));
            end
            default: begin
               applyStimulus(OP_DMEM_RD, 64'(idx) << 3, 64'd0);
               checkOutput("randDmemRd", expDmem[0][idx], int'($urandom_range(0, 3)));
            end
         endcase
      end

      applyStimulus(OP_RUN, 64'd0, 64'd0);
      @(negedge clk);
      checkValue("cpuEnAfterRun", 64'(cpuEn[0]), 64'd1);
      cmdValid = 1'b1; cmdOp = OP_DMEM_WR; cmdAddr = 64'h30; cmdData = 64'h1122_3344_5566_7788;
      repeat (3) begin
         @(negedge clk);
         checkValue("stallDmemWr", 64'(cmdReady[0]), 64'd0);
      end
      cmdOp = OP_HALT;
      #1 checkValue("haltReady", 64'(cmdReady[0]), 64'd1);
      @(posedge clk);
      #1 cmdValid = 1'b0; cmdOp = OP_NOP;
      @(negedge clk);
      checkValue("cpuEnAfterHalt", 64'(cpuEn[0]), 64'd0);
      applyStimulus(OP_DMEM_WR, 64'h30, 64'h1122_3344_5566_7788);
      applyStimulus(OP_DMEM_RD, 64'h30, 64'd0);
      checkOutput("stalledWrDone", 64'h1122_3344_5566_7788, 1);

      applyStimulus(OP_RUN, 64'd0, 64'd0);
      runAt = acceptCycle;
      repeat (99) @(posedge clk);
      applyStimulus(OP_HALT, 64'd0, 64'd0);
      haltAt = acceptCycle;
      checkCycles("cycles100", haltAt - runAt);

      applyStimulus(OP_HALT, 64'd0, 64'd0);
      @(negedge clk);
      checkValue("haltWhileHalted", 64'(cpuEn[0]), 64'd0);
      applyStimulus(OP_RUN, 64'd0, 64'd0);
      runAt = acceptCycle;
      repeat (20) @(posedge clk);
      applyStimulus(OP_RUN, 64'd0, 64'd0);
      @(negedge clk);
      checkValue("runWhileRunning", 64'(cpuEn[0]), 64'd1);
      repeat (30) @(posedge clk);
      applyStimulus(OP_NOP, 64'd0, 64'd0);
      applyStimulus(OP_HALT, 64'd0, 64'd0);
      haltAt = acceptCycle;
      checkCycles("cyclesRunRun", haltAt - runAt);

      selB = 1'b1;
      applyStimulus(OP_IMEM_WR, 64'h40, 64'h1234_5678);
      applyStimulus(OP_IMEM_RD, 64'h40, 64'd0);
      @(posedge clk);
      #2 arst[1] = 1'b1;
      @(negedge clk);
      checkIdle(1, "midWaitReset");
      checkValue("readyDuringReset", 64'(cmdReady[1]), 64'd0);
      arst[1] = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (rspValid[1]) seen++;
      end
      checkValue("noRspAfterReset", 64'(seen), 64'd0);
      checkIdle(1, "afterWaitReset");
      applyStimulus(OP_IMEM_RD, 64'h40, 64'd0);
      checkOutput("rdAfterReset", 64'h0000_0000_1234_5678, 1);
      rdata = {$urandom, $urandom};
      applyStimulus(OP_DMEM_WR, 64'h18, rdata);
      applyStimulus(OP_DMEM_RD, 64'h18, 64'd0);
      checkOutput("lat3DmemRd", expDmem[1][3], 2);
      selB = 1'b0;

      checkValue("strobeExclusive", 64'(strobeClash), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cpu_host_loader.md
Name: cpu_host_loader

Overview:
- Host-side initiator for the CPU's external memory-access ports: instruction-memory port (addr_ext / wen_ext / ren_ext / wdata_ext / rdata_ext) and data-memory port (the *_2 set).
- Accepts a valid/ready command stream: write/read either memory, start/stop the core.
- Drives the CPU enable input and returns read data on a valid/ready response channel.
- Sits between the testbench or debug host and the cpu top.

Parameters:
- ADDR_W, 64: address width of both ext ports.
- RD_LAT, 1: cycles from the ren strobe to valid rdata on either SRAM (range 1..4).

Ports:
- clk  in  1  main clock
- arst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_op  in  3  opcode (see Behaviour)
- cmd_addr  in  ADDR_W  byte address
- cmd_data  in  64  write data; [31:0] used for imem
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_data  out  64  read data; imem reads zero-extended
- cpu_enable  out  1  drives cpu enable
- imem_addr  out  ADDR_W  to addr_ext
- imem_wen  out  1  to wen_ext
- imem_ren  out  1  to ren_ext
- imem_wdata  out  32  to wdata_ext
- imem_rdata  in  32  from rdata_ext
- dmem_addr  out  ADDR_W  to addr_ext_2
- dmem_wen  out  1  to wen_ext_2
- dmem_ren  out  1  to ren_ext_2
- dmem_wdata  out  64  to wdata_ext_2
- dmem_rdata  in  64  from rdata_ext_2

Behaviour:
- Clock is clk. Reset is arst, asynchronous and active-high. Reset clears all registers and outputs to 0: cpu_enable=0, all strobes=0, rsp_valid=0, rsp_data=0, addr/wdata=0.
- While arst is asserted, cmd_ready=0.
- Reset mid-operation drops any pending strobe or response.
- Opcodes: 0 NOP, 1 IMEM_WR, 2 DMEM_WR, 3 IMEM_RD, 4 DMEM_RD, 5 RUN, 6 HALT, 7 RD_CYCLES (optional feature).
- FSM states: S_IDLE, S_WRITE, S_READ, S_WAIT, S_RESP.
- cmd_ready is combinational and is high only in S_IDLE.
  - While cpu_enable=1, cmd_ready=1 only for NOP, RUN, HALT and RD_CYCLES; memory ops stall until HALT.
  - HALT is always accepted in S_IDLE, so the stall cannot deadlock.
- Address and data are registered on accept and held until the next accepted memory command.
- Write path:
  - S_IDLE accepts a write and moves to S_WRITE.
  - S_WRITE drives the selected wen for exactly 1 cycle with registered addr/data, then returns to S_IDLE.
  - Throughput: 1 write per 2 cycles.
- Read path:
  - S_IDLE accepts a read and moves to S_READ.
  - S_READ drives the selected ren for 1 cycle.
  - S_WAIT counts RD_LAT-1 additional cycles (skipped if RD_LAT=1).
  - rdata is captured into rsp_data on the cycle RD_LAT after the ren strobe; the FSM then enters S_RESP with rsp_valid=1.
- S_RESP:
  - rsp_valid and rsp_data are held stable until rsp_ready.
  - On valid&&ready, rsp_valid falls the next cycle, FSM returns to S_IDLE, and cmd_ready rises that cycle.
- Only one memory transaction is ever outstanding. Strobes to the two memories are never asserted together.
- RUN sets cpu_enable=1 from the cycle after accept; HALT clears it likewise.
- RUN while running, HALT while halted, and NOP are no-ops consuming 1 accept cycle.
- All outputs are registered, except cmd_ready.

Optional Feature:
- Macro: HOST_RUN_CYCLE_CNT_EN.
- With it defined:
  - 64-bit counter increments each cycle cpu_enable=1.
  - It clears on RUN accepted while halted and holds on HALT.
  - RD_CYCLES returns the counter through the S_RESP path with the same handshake.
  - RD_CYCLES is accepted while running.
- Without it: RD_CYCLES behaves as NOP and no response is produced.

Decomposition:
- Package cpu_host_loader_pkg holds:
  - opcode enum (3-bit) with the values above;
  - FSM state enum;
  - constant RD_LAT_MAX=4.
- No sub-module: the single FSM plus datapath registers stays under 300 lines.

Test Plan:
- After reset, IMEM_WR addr=0x8 data=0x00500093 → exactly one cycle with imem_wen=1, imem_addr=0x8, imem_wdata=0x00500093; dmem strobes stay 0.
- DMEM_WR addr=0x10 data=0xDEADBEEFCAFEF00D, then DMEM_RD addr=0x10 with RD_LAT=1 and rsp_ready held 0 for 5 cycles → rsp_valid stays high with rsp_data=0xDEADBEEFCAFEF00D, then drops 1 cycle after rsp_ready.
- IMEM_RD of a word 0x00A00113 → rsp_data=0x0000000000A00113.
- RUN, then DMEM_WR presented → cpu_enable=1 and cmd_ready=0 for DMEM_WR; HALT accepted; cpu_enable=0 next cycle; the DMEM_WR then completes.
- arst pulsed during S_WAIT of a read → rsp_valid never rises, all outputs 0; a new IMEM_RD afterwards responds normally.
- With HOST_RUN_CYCLE_CNT_EN: RUN, wait 100 cycles, HALT, RD_CYCLES → rsp_data=100. Without the macro, RD_CYCLES yields no response.
